// File: rtl/axicb_slv_switch_wr_n.sv
// AXI crossbar write-path slave switch: AW decode, in-order W routing, DECERR sink, round-robin B.
// Optional B output register slice enabled by defining AXICB_SWW_BSLICE_EN.
module axicb_slv_switch_wr_n #(
    parameter int                           AXI_ADDR_W     = 32,
    parameter int                           AXI_ID_W       = 8,
    parameter int                           SLV_NB         = 4,
    parameter logic [SLV_NB-1:0]            MST_ROUTES     = {SLV_NB{1'b1}},
    parameter logic [SLV_NB*AXI_ADDR_W-1:0] SLV_START_ADDR = '0,
    parameter logic [SLV_NB*AXI_ADDR_W-1:0] SLV_END_ADDR   = '1,
    parameter int                           RT_DEPTH_W     = 3,
    parameter int                           DE_DEPTH_W     = 2,
    parameter int                           AWCH_W         = AXI_ADDR_W + AXI_ID_W,
    parameter int                           WCH_W          = 8,
    parameter int                           BCH_W          = AXI_ID_W + 2
) (
    input  logic                     aclk,
    input  logic                     arst,
    input  logic                     srst,
    input  logic                     i_awvalid,
    output logic                     i_awready,
    input  logic [AWCH_W-1:0]        i_awch,
    input  logic                     i_wvalid,
    output logic                     i_wready,
    input  logic                     i_wlast,
    input  logic [WCH_W-1:0]         i_wch,
    output logic                     i_bvalid,
    input  logic                     i_bready,
    output logic [BCH_W-1:0]         i_bch,
    output logic [SLV_NB-1:0]        o_awvalid,
    input  logic [SLV_NB-1:0]        o_awready,
    output logic [AWCH_W-1:0]        o_awch,
    output logic [SLV_NB-1:0]        o_wvalid,
    input  logic [SLV_NB-1:0]        o_wready,
    output logic [SLV_NB-1:0]        o_wlast,
    output logic [WCH_W-1:0]         o_wch,
    input  logic [SLV_NB-1:0]        o_bvalid,
    output logic [SLV_NB-1:0]        o_bready,
    input  logic [SLV_NB*BCH_W-1:0]  o_bch
);

    localparam int SIW      = (SLV_NB > 1) ? $clog2(SLV_NB) : 1;
    localparam int RTE_W    = 1 + SLV_NB + AXI_ID_W;
    localparam int RT_DEPTH = 1 << RT_DEPTH_W;
    localparam int DE_DEPTH = 1 << DE_DEPTH_W;

    logic rst_any;
    assign rst_any = arst | srst;

    logic [AXI_ADDR_W-1:0] aw_addr;
    logic [AXI_ID_W-1:0]   aw_id;
    logic [SLV_NB-1:0]     tgt;
    logic                  aw_err;

    assign aw_addr = i_awch[AXI_ADDR_W-1:0];
    assign aw_id   = i_awch[AXI_ADDR_W+:AXI_ID_W];
    assign o_awch  = i_awch;
    assign o_wch   = i_wch;

    // Scan from the top so the lowest matching window wins.
    always_comb begin
        tgt = '0;
        for (int k = SLV_NB - 1; k >= 0; k--) begin
            if (MST_ROUTES[k] &&
                aw_addr >= SLV_START_ADDR[k*AXI_ADDR_W+:AXI_ADDR_W] &&
                aw_addr <= SLV_END_ADDR[k*AXI_ADDR_W+:AXI_ADDR_W]) begin
                tgt    = '0;
                tgt[k] = 1'b1;
            end
        end
    end
    assign aw_err = ~|tgt;

    // Route FIFO
    logic [RTE_W-1:0]    rt_mem [RT_DEPTH];
    logic [RT_DEPTH_W:0] rt_wr_q, rt_wr_d, rt_rd_q, rt_rd_d;
    logic                rt_full, rt_empty, rt_push, rt_pop;
    logic [RTE_W-1:0]    rt_head;
    logic                h_err;
    logic [SLV_NB-1:0]   h_tgt;
    logic [AXI_ID_W-1:0] h_id;

    assign rt_empty = (rt_wr_q == rt_rd_q);
    assign rt_full  = (rt_wr_q[RT_DEPTH_W] != rt_rd_q[RT_DEPTH_W]) &&
                      (rt_wr_q[RT_DEPTH_W-1:0] == rt_rd_q[RT_DEPTH_W-1:0]);
    assign rt_head  = rt_mem[rt_rd_q[RT_DEPTH_W-1:0]];
    assign h_err    = rt_head[RTE_W-1];
    assign h_tgt    = rt_head[AXI_ID_W+:SLV_NB];
    assign h_id     = rt_head[AXI_ID_W-1:0];
    assign rt_push  = i_awvalid & i_awready;
    assign rt_pop   = i_wvalid & i_wready & i_wlast;
    assign rt_wr_d  = rt_wr_q + {{RT_DEPTH_W{1'b0}}, rt_push};
    assign rt_rd_d  = rt_rd_q + {{RT_DEPTH_W{1'b0}}, rt_pop};

    // DECERR FIFO
    logic [AXI_ID_W-1:0] de_mem [DE_DEPTH];
    logic [DE_DEPTH_W:0] de_wr_q, de_wr_d, de_rd_q, de_rd_d;
    logic                de_full, de_empty, de_push, de_pop;
    logic [AXI_ID_W-1:0] de_id;

    assign de_empty = (de_wr_q == de_rd_q);
    assign de_full  = (de_wr_q[DE_DEPTH_W] != de_rd_q[DE_DEPTH_W]) &&
                      (de_wr_q[DE_DEPTH_W-1:0] == de_rd_q[DE_DEPTH_W-1:0]);
    assign de_id    = de_mem[de_rd_q[DE_DEPTH_W-1:0]];
    assign de_push  = rt_pop & h_err;
    assign de_wr_d  = de_wr_q + {{DE_DEPTH_W{1'b0}}, de_push};
    assign de_rd_d  = de_rd_q + {{DE_DEPTH_W{1'b0}}, de_pop};

    always_comb begin
        o_awvalid = '0;
        i_awready = 1'b0;
        if (!rst_any && !rt_full) begin
            if (aw_err) begin
                i_awready = 1'b1;
            end else begin
                o_awvalid = tgt & {SLV_NB{i_awvalid}};
                i_awready = |(tgt & o_awready);
            end
        end
    end

    always_comb begin
        o_wvalid = '0;
        o_wlast  = '0;
        i_wready = 1'b0;
        if (!rst_any && !rt_empty) begin
            if (h_err) begin
                i_wready = i_wlast ? ~de_full : 1'b1;
            end else begin
                o_wvalid = h_tgt & {SLV_NB{i_wvalid}};
                o_wlast  = h_tgt & {SLV_NB{i_wlast}};
                i_wready = |(h_tgt & o_wready);
            end
        end
    end

    // B arbitration
    logic [SIW-1:0]   ptr_q, ptr_d, arb_idx, gnt, lock_idx_q, lock_idx_d;
    logic             arb_hit, lock_q, lock_d, slv_sel;
    logic             a_valid, a_ready;
    logic [BCH_W-1:0] a_bch;

    always_comb begin
        int j;
        j       = 0;
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int i = 0; i < SLV_NB; i++) begin
            j = int'(ptr_q) + 1 + i;
            if (j >= SLV_NB) j = j - SLV_NB;
            if (!arb_hit && o_bvalid[SIW'(j)]) begin
                arb_hit = 1'b1;
                arb_idx = SIW'(j);
            end
        end
    end

    // A locked slave grant keeps ownership even if a DECERR arrives meanwhile, so i_bch never changes mid-handshake.
    always_comb begin
        gnt      = lock_q ? lock_idx_q : arb_idx;
        slv_sel  = 1'b0;
        a_valid  = 1'b0;
        a_bch    = '0;
        o_bready = '0;
        de_pop   = 1'b0;
        if (!rst_any) begin
            if (!de_empty && !lock_q) begin
                a_valid = 1'b1;
                a_bch   = {2'b11, de_id};
                de_pop  = a_ready;
            end else if (lock_q || arb_hit) begin
                slv_sel       = 1'b1;
                a_valid       = o_bvalid[gnt];
                a_bch         = o_bch[gnt*BCH_W+:BCH_W];
                o_bready[gnt] = a_ready;
            end
        end
    end

    assign lock_d     = slv_sel & a_valid & ~a_ready;
    assign lock_idx_d = gnt;
    assign ptr_d      = (slv_sel & a_valid & a_ready) ? gnt : ptr_q;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            rt_wr_q    <= '0;
            rt_rd_q    <= '0;
            de_wr_q    <= '0;
            de_rd_q    <= '0;
            ptr_q      <= SIW'(SLV_NB - 1);
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (srst) begin
            rt_wr_q    <= '0;
            rt_rd_q    <= '0;
            de_wr_q    <= '0;
            de_rd_q    <= '0;
            ptr_q      <= SIW'(SLV_NB - 1);
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rt_wr_q    <= rt_wr_d;
            rt_rd_q    <= rt_rd_d;
            de_wr_q    <= de_wr_d;
            de_rd_q    <= de_rd_d;
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (rt_push) rt_mem[rt_wr_q[RT_DEPTH_W-1:0]] <= {aw_err, tgt, aw_id};
        if (de_push) de_mem[de_wr_q[DE_DEPTH_W-1:0]] <= h_id;
    end

`ifdef AXICB_SWW_BSLICE_EN
    logic [BCH_W-1:0] sk_mem [2];
    logic             sk_wr_q, sk_wr_d, sk_rd_q, sk_rd_d;
    logic [1:0]       sk_cnt_q, sk_cnt_d;
    logic             sk_push, sk_pop;

    assign a_ready  = (sk_cnt_q != 2'd2);
    assign sk_push  = a_valid & a_ready;
    assign sk_pop   = i_bvalid & i_bready;
    assign i_bvalid = (sk_cnt_q != 2'd0) & ~rst_any;
    assign i_bch    = sk_mem[sk_rd_q];
    assign sk_wr_d  = sk_wr_q ^ sk_push;
    assign sk_rd_d  = sk_rd_q ^ sk_pop;
    assign sk_cnt_d = sk_cnt_q + {1'b0, sk_push} - {1'b0, sk_pop};

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            sk_wr_q  <= 1'b0;
            sk_rd_q  <= 1'b0;
            sk_cnt_q <= '0;
        end else if (srst) begin
            sk_wr_q  <= 1'b0;
            sk_rd_q  <= 1'b0;
            sk_cnt_q <= '0;
        end else begin
            sk_wr_q  <= sk_wr_d;
            sk_rd_q  <= sk_rd_d;
            sk_cnt_q <= sk_cnt_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (sk_push) sk_mem[sk_wr_q] <= a_bch;
    end
`else
    assign a_ready  = i_bready;
    assign i_bvalid = a_valid;
    assign i_bch    = a_bch;
`endif

endmodule

// File: tb/tb_axicb_slv_switch_wr_n.sv
// Scoreboard bench for axicb_slv_switch_wr_n: decode, W routing order, DECERR, B arbitration, resets.
module tb_axicb_slv_switch_wr_n;

    localparam int NB = 4, AW = 32, IW = 8, AWCH = 40, WCH = 8, BCH = 10;
    localparam logic [NB*AW-1:0] STARTS = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
    localparam logic [NB*AW-1:0] ENDS   = {32'h3FFF, 32'h2FFF, 32'h1FFF, 32'h0FFF};

    logic            aclk = 1'b0, arst = 1'b1, srst = 1'b0;
    logic            i_awvalid = 1'b0, i_awready;
    logic [AWCH-1:0] i_awch = '0;
    logic            i_wvalid = 1'b0, i_wready, i_wlast = 1'b0;
    logic [WCH-1:0]  i_wch = '0;
    logic            i_bvalid, i_bready = 1'b1;
    logic [BCH-1:0]  i_bch;
    logic [NB-1:0]   o_awvalid, o_awready = '1;
    logic [AWCH-1:0] o_awch;
    logic [NB-1:0]   o_wvalid, o_wready = '1, o_wlast;
    logic [WCH-1:0]  o_wch;
    logic [NB-1:0]   o_bvalid = '0, o_bready;
    logic [NB*BCH-1:0] o_bch = '0;

    logic            r_awvalid = 1'b0, r_awready, r_wvalid = 1'b0, r_wready, r_wlast = 1'b0;
    logic [AWCH-1:0] r_awch = '0, r_oawch;
    logic [WCH-1:0]  r_wch = '0, r_owch;
    logic            r_bvalid, r_bready = 1'b1;
    logic [BCH-1:0]  r_bch;
    logic [NB-1:0]   r_oawvalid, r_owvalid, r_owlast, r_obready;

    int n_chk = 0, n_fail = 0;
    logic [63:0] aw_q[$], w_q[$], b_q[$];
    logic [NB-1:0] last_oaw, w_or;
    int stalls;

    always #5 aclk = ~aclk;

    axicb_slv_switch_wr_n #(
        .AXI_ADDR_W(AW), .AXI_ID_W(IW), .SLV_NB(NB), .MST_ROUTES(4'b1111),
        .SLV_START_ADDR(STARTS), .SLV_END_ADDR(ENDS), .RT_DEPTH_W(3), .DE_DEPTH_W(2),
        .AWCH_W(AWCH), .WCH_W(WCH), .BCH_W(BCH)
    ) dut (
        .aclk(aclk), .arst(arst), .srst(srst),
        .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awch(i_awch),
        .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wch(i_wch),
        .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bch(i_bch),
        .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
        .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
        .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch)
    );

    axicb_slv_switch_wr_n #(
        .AXI_ADDR_W(AW), .AXI_ID_W(IW), .SLV_NB(NB), .MST_ROUTES(4'b1101),
        .SLV_START_ADDR(STARTS), .SLV_END_ADDR(ENDS), .RT_DEPTH_W(3), .DE_DEPTH_W(2),
        .AWCH_W(AWCH), .WCH_W(WCH), .BCH_W(BCH)
    ) dut_r (
        .aclk(aclk), .arst(arst), .srst(srst),
        .i_awvalid(r_awvalid), .i_awready(r_awready), .i_awch(r_awch),
        .i_wvalid(r_wvalid), .i_wready(r_wready), .i_wlast(r_wlast), .i_wch(r_wch),
        .i_bvalid(r_bvalid), .i_bready(r_bready), .i_bch(r_bch),
        .o_awvalid(r_oawvalid), .o_awready(4'b1111), .o_awch(r_oawch),
        .o_wvalid(r_owvalid), .o_wready(4'b1111), .o_wlast(r_owlast), .o_wch(r_owch),
        .o_bvalid(4'b0000), .o_bready(r_obready), .o_bch({NB*BCH{1'b0}})
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard side: pop and compare on every handshake the DUT presents.
    always @(negedge aclk) begin
        for (int k = 0; k < NB; k++) begin
            if (o_awvalid[k] && o_awready[k]) begin
                if (aw_q.size() == 0) chk("aw_unexp", 64'(k), 64'hFF);
                else chk("aw", {4'(k), o_awch}, aw_q.pop_front());
            end
            if (o_wvalid[k] && o_wready[k]) begin
                if (w_q.size() == 0) chk("w_unexp", 64'(k), 64'hFF);
                else chk("w", {4'(k), o_wlast[k], o_wch}, w_q.pop_front());
            end
        end
        if (i_bvalid && i_bready) begin
            if (b_q.size() == 0) chk("b_unexp", 64'(i_bch), 64'hFFFF);
            else chk("b", 64'(i_bch), b_q.pop_front());
        end
    end

    task automatic aw_send(input logic [31:0] a, input logic [7:0] id, input int s);
        int n = 0;
        if (s >= 0) aw_q.push_back({4'(s), id, a});
        i_awvalid = 1'b1;
        i_awch    = {id, a};
        @(negedge aclk);
        while (!i_awready && n < 50) begin n++; @(negedge aclk); end
        if (!i_awready) chk("aw_timeout", 0, 1);
        last_oaw = o_awvalid;
        @(posedge aclk); #1;
        i_awvalid = 1'b0;
    endtask

    task automatic w_send(input int nb, input int s, input logic [7:0] base, input bit dolast);
        w_or   = '0;
        stalls = 0;
        for (int b = 0; b < nb; b++) begin
            int n = 0;
            i_wvalid = 1'b1;
            i_wch    = base + 8'(b);
            i_wlast  = dolast && (b == nb - 1);
            if (s >= 0) w_q.push_back({4'(s), i_wlast, i_wch});
            @(negedge aclk);
            while (!i_wready && n < 50) begin n++; @(negedge aclk); end
            if (!i_wready) chk("w_timeout", 0, 1);
            stalls += n;
            w_or |= o_wvalid;
            @(posedge aclk); #1;
        end
        i_wvalid = 1'b0;
        i_wlast  = 1'b0;
    endtask

    task automatic sb_resp(input int k, input logic [7:0] id);
        int n = 0;
        b_q.push_back({2'b00, id});
        o_bvalid[k] = 1'b1;
        o_bch[k*BCH+:BCH] = {2'b00, id};
        @(negedge aclk);
        while (!o_bready[k] && n < 50) begin n++; @(negedge aclk); end
        if (!o_bready[k]) chk("b_timeout", 0, 1);
        @(posedge aclk); #1;
        o_bvalid[k] = 1'b0;
    endtask

    logic [7:0]    t_ids [5] = '{8'h10, 8'h11, 8'h11, 8'h12, 8'h13};
    logic          t_rdy [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [NB-1:0] t_obr [5] = '{4'b0001, 4'b0000, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        #1;
        @(negedge aclk);
        chk("rst_awrdy", i_awready, 0);
        chk("rst_wrdy", i_wready, 0);
        chk("rst_bvld", i_bvalid, 0);
        @(posedge aclk); #1 arst = 1'b0;
        @(negedge aclk);
        chk("idle_wrdy", i_wready, 0);
        chk("idle_bvld", i_bvalid, 0);
        @(posedge aclk); #1;

        // mapped burst to slave 1 and its B
        aw_send(32'h1004, 8'd5, 1);
        chk("t1_oaw", last_oaw, 4'b0010);
        w_send(4, 1, 8'hA0, 1);
        chk("t1_wport", w_or, 4'b0010);
        sb_resp(1, 8'd5);

        // unmapped burst sunk, DECERR the cycle after wlast
        b_q.push_back({2'b11, 8'd7});
        aw_send(32'h9000, 8'd7, -1);
        chk("t2_oaw", last_oaw, 0);
        w_send(3, -1, 8'hB0, 1);
        chk("t2_wport", w_or, 0);
        chk("t2_stall", stalls, 0);
        chk("t2_bvld", i_bvalid, 1);
        chk("t2_bch", i_bch, {2'b11, 8'd7});
        @(posedge aclk); #1;

        // forbidden route on dut_r
        r_awvalid = 1'b1;
        r_awch = {8'd3, 32'h1000};
        @(negedge aclk);
        chk("t3_awrdy", r_awready, 1);
        chk("t3_oaw", r_oawvalid, 0);
        @(posedge aclk); #1;
        r_awvalid = 1'b0; r_wvalid = 1'b1; r_wlast = 1'b1; r_wch = 8'h55;
        @(negedge aclk);
        chk("t3_wrdy", r_wready, 1);
        chk("t3_ow", r_owvalid, 0);
        @(posedge aclk); #1;
        r_wvalid = 1'b0; r_wlast = 1'b0;
        @(negedge aclk);
        chk("t3_b", {r_bvalid, r_bch}, {1'b1, 2'b11, 8'd3});
        @(posedge aclk); #1;

        // in-order routing, W late
        aw_send(32'h2000, 8'd1, 2);
        aw_send(32'h0010, 8'd2, 0);
        repeat (3) @(posedge aclk);
        #1;
        w_send(2, 2, 8'h20, 1);
        w_send(2, 0, 8'h30, 1);
        for (int i = 0; i < 8; i++) aw_send(32'h3000 + 32'(i * 4), 8'(i), 3);
        i_awvalid = 1'b1;
        i_awch = {8'h99, 32'h3000};
        @(negedge aclk);
        chk("t4_full_awrdy", i_awready, 0);
        chk("t4_full_oaw", o_awvalid, 0);
        @(posedge aclk); #1;
        i_awvalid = 1'b0;
        for (int i = 0; i < 8; i++) w_send(1, 3, 8'h40 + 8'(i), 1);
        i_wvalid = 1'b1; i_wlast = 1'b1;
        @(negedge aclk);
        chk("t4_empty_wrdy", i_wready, 0);
        chk("t4_empty_ow", o_wvalid, 0);
        @(posedge aclk); #1;
        i_wvalid = 1'b0; i_wlast = 1'b0;

        // DECERR FIFO full blocks only the last beat
        i_bready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            b_q.push_back({2'b11, 8'h60 + 8'(i)});
            aw_send(32'h9000, 8'h60 + 8'(i), -1);
            w_send(1, -1, 8'h00, 1);
        end
        b_q.push_back({2'b11, 8'h64});
        aw_send(32'h9000, 8'h64, -1);
        i_wvalid = 1'b1; i_wlast = 1'b1;
        @(negedge aclk);
        chk("t5_defull_wrdy", i_wready, 0);
        chk("t5_de_bch", {i_bvalid, i_bch}, {1'b1, 2'b11, 8'h60});
        @(posedge aclk); #1;
        i_wvalid = 1'b0; i_wlast = 1'b0;
        i_bready = 1'b1;
        w_send(1, -1, 8'h00, 1);
        chk("t5_stall", stalls, 1);
        repeat (8) @(posedge aclk);
        #1;

        // srst, then round-robin with locked grant
        srst = 1'b1;
        @(negedge aclk);
        chk("srst_awrdy", i_awready, 0);
        @(posedge aclk); #1 srst = 1'b0;
        for (int k = 0; k < NB; k++) o_bch[k*BCH+:BCH] = {2'b00, 8'h10 + 8'(k)};
        o_bvalid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            i_bready = t_rdy[c];
            if (t_rdy[c]) b_q.push_back({2'b00, t_ids[c]});
            @(negedge aclk);
            chk("t6_bch", i_bch, {2'b00, t_ids[c]});
            chk("t6_obrdy", o_bready, t_obr[c]);
            @(posedge aclk); #1;
        end
        o_bvalid = '0;
        i_bready = 1'b1;

        // arst mid-burst
        aw_send(32'h1000, 8'd9, 1);
        w_send(2, 1, 8'h70, 0);
        arst = 1'b1;
        @(negedge aclk);
        chk("t7_awrdy", i_awready, 0);
        chk("t7_wrdy", i_wready, 0);
        chk("t7_bvld", i_bvalid, 0);
        chk("t7_ow", o_wvalid, 0);
        @(posedge aclk); #1 arst = 1'b0;
        aw_send(32'h2004, 8'd10, 2);
        chk("t7_oaw", last_oaw, 4'b0100);
        w_send(1, 2, 8'h80, 1);
        @(posedge aclk); #1;

        chk("aw_left", aw_q.size(), 0);
        chk("w_left", w_q.size(), 0);
        chk("b_left", b_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
